// File: rtl/txmit_buffer.sv
// Transmit buffer: deserializes an LSB-first bit stream into bytes, queues them in a FIFO and
// hands them to the transmitter with an rfd/dav/ack handshake after a fixed pop latency.
module txmit_buffer #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 16
) (
   input  logic       clk_1200,
   input  logic       reset,
   input  logic       datain,
   input  logic       start,
   input  logic       ack_tx,
   input  logic       rfd_tx,
   output logic       tx_full,
   output logic       tx_empty,
   output logic [7:0] dataout,
   output logic       dav_tx,
   output logic       ack
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = 4;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
   localparam logic [LW-1:0] LatInit = LW'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StPresent} state_e;

   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic [7:0]    byte_in;
   logic          wr_en;
   logic          ack_q;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q;

   state_e        state_q, state_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [7:0]    hold_q, hold_d;
   logic [7:0]    dout_q, dout_d;
   logic          dav_q, dav_d;
   logic          pop;

   // Right shift with the new bit at the MSB leaves the first bit in bit0 after eight edges.
   assign byte_in = {datain, shift_q[7:1]};
   assign wr_en   = start && (bit_cnt_q == 3'd7) && !full_q;

   always_ff @(posedge clk_1200) begin
      if (reset) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ack_q     <= 1'b0;
      end else begin
         ack_q <= wr_en;
         if (start) begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end else begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
         end
      end
   end

   always_comb begin
      count_d = count_q + CW'(wr_en) - CW'(pop);
   end

   always_ff @(posedge clk_1200) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == FullCnt);
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk_1200) begin
      if (!reset && wr_en) mem_q[wr_ptr_q] <= byte_in;
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      hold_d  = hold_q;
      dout_d  = dout_q;
      dav_d   = dav_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rfd_tx && !empty_q) begin
               pop     = 1'b1;
               hold_d  = mem_q[rd_ptr_q];
               lat_d   = LatInit;
               state_d = StWait;
            end
         end
         StWait: begin
            if (lat_q == '0) begin
               dout_d  = hold_q;
               dav_d   = 1'b1;
               state_d = StPresent;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         StPresent: begin
            if (ack_tx) begin
               dav_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_1200) begin
      if (reset) begin
         state_q <= StIdle;
         lat_q   <= '0;
         hold_q  <= '0;
         dout_q  <= '0;
         dav_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         hold_q  <= hold_d;
         dout_q  <= dout_d;
         dav_q   <= dav_d;
      end
   end

   assign tx_full  = full_q;
   assign tx_empty = empty_q;
   assign dataout  = dout_q;
   assign dav_tx   = dav_q;
   assign ack      = ack_q;

endmodule

// File: tb/tb_txmit_buffer.sv
// Directed plus randomized bench for txmit_buffer, checked every cycle against a queue-based model.
module tb_txmit_buffer;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned LATENCY = 2;

   logic       clk_1200 = 1'b0;
   logic       reset    = 1'b1;
   logic       datain   = 1'b0;
   logic       start    = 1'b0;
   logic       ack_tx   = 1'b0;
   logic       rfd_tx   = 1'b0;
   logic       tx_full, tx_empty, dav_tx, ack;
   logic [7:0] dataout;

   txmit_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk_1200 (clk_1200),
      .reset    (reset),
      .datain   (datain),
      .start    (start),
      .ack_tx   (ack_tx),
      .rfd_tx   (rfd_tx),
      .tx_full  (tx_full),
      .tx_empty (tx_empty),
      .dataout  (dataout),
      .dav_tx   (dav_tx),
      .ack      (ack)
   );

   always #5 clk_1200 = ~clk_1200;

   int n_total = 0;
   int n_pass  = 0;
   int ack_seen = 0;

   // Reference model: byte queue, partial-byte bit list, and a countdown to presentation.
   logic [7:0] fifo [$];
   logic [7:0] m_byte;
   int         m_nbits = 0;
   logic [7:0] m_held = 8'h00;
   logic [7:0] m_dout = 8'h00;
   int         m_wait = 0;
   logic       m_dav = 1'b0;
   logic       m_ack = 1'b0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_edge(input logic r, input logic s, input logic d, input logic rf,
                             input logic ak);
      logic pre_full, pre_empty;
      if (r) begin
         fifo.delete();
         m_nbits = 0;
         m_wait  = 0;
         m_dav   = 1'b0;
         m_dout  = 8'h00;
         m_held  = 8'h00;
         m_ack   = 1'b0;
         return;
      end
      pre_full  = (fifo.size() == DEPTH);
      pre_empty = (fifo.size() == 0);
      if (m_dav) begin
         if (ak) m_dav = 1'b0;
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_dav  = 1'b1;
            m_dout = m_held;
         end
      end else if (rf && !pre_empty) begin
         m_held = fifo.pop_front();
         m_wait = LATENCY;
      end
      m_ack = 1'b0;
      if (s) begin
         m_byte[m_nbits] = d;
         m_nbits++;
         if (m_nbits == 8) begin
            if (!pre_full) begin
               fifo.push_back(m_byte);
               m_ack = 1'b1;
            end
            m_nbits = 0;
         end
      end else begin
         m_nbits = 0;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic d, input logic rf,
                       input logic ak);
      reset  = r;
      start  = s;
      datain = d;
      rfd_tx = rf;
      ack_tx = ak;
      @(posedge clk_1200);
      model_edge(r, s, d, rf, ak);
      #1;
      if (ack === 1'b1) ack_seen++;
      check("tx_empty", {7'd0, tx_empty}, {7'd0, fifo.size() == 0});
      check("tx_full",  {7'd0, tx_full},  {7'd0, fifo.size() == DEPTH});
      check("ack",      {7'd0, ack},      {7'd0, m_ack});
      check("dav_tx",   {7'd0, dav_tx},   {7'd0, m_dav});
      check("dataout",  dataout,          m_dout);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rf, input logic ak);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, b[i], rf, ak);
   endtask

   initial begin
      logic [7:0] got [$];
      int         rf_pct;

      // Reset then idle
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_empty", {7'd0, tx_empty}, 8'd1);
      check("rst_full",  {7'd0, tx_full},  8'd0);
      check("rst_dav",   {7'd0, dav_tx},   8'd0);
      check("rst_ack",   {7'd0, ack},      8'd0);
      check("rst_dout",  dataout,          8'h00);

      // Alternating stream, first bit 1 -> 8'h55
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
         if (i < 7) check("alt_ack_low", {7'd0, ack}, 8'd0);
      end
      check("alt_ack_pulse", {7'd0, ack},      8'd1);
      check("alt_nonempty",  {7'd0, tx_empty}, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("alt_ack_one", {7'd0, ack}, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("alt_byte", dataout, 8'h55);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Handshake latency with 8'hA3
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'hA3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hs_dav_early", {7'd0, dav_tx}, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hs_dav", {7'd0, dav_tx}, 8'd1);
      check("hs_data", dataout, 8'hA3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hs_dav_hold", {7'd0, dav_tx}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("hs_dav_fall", {7'd0, dav_tx},   8'd0);
      check("hs_data_keep", dataout,         8'hA3);
      check("hs_empty",    {7'd0, tx_empty}, 8'd1);

      // Fill and overflow
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < 17; b++) begin
         send_byte(8'(b), 1'b0, 1'b0);
         if (b == 15) begin
            check("fill_full", {7'd0, tx_full}, 8'd1);
            check("fill_ack16", {7'd0, ack}, 8'd1);
         end
      end
      check("ovf_no_ack", {7'd0, ack},     8'd0);
      check("ovf_full",   {7'd0, tx_full}, 8'd1);
      for (int c = 0; c < 300 && got.size() < 16; c++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         if (dav_tx === 1'b1) got.push_back(dataout);
      end
      check("drain_count", 8'(got.size()), 8'd16);
      for (int i = 0; i < got.size(); i++) check("drain_order", got[i], 8'(i));
      check("drain_empty", {7'd0, tx_empty}, 8'd1);

      // Start gating: 5 stray bits, gap, then 8'hC6
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ack_seen = 0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'hC6, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gate_acks", 8'(ack_seen), 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("gate_single", {7'd0, tx_empty}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gate_byte", dataout, 8'hC6);
      check("gate_dav", {7'd0, dav_tx}, 8'd1);

      // Reset during PRESENT
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rp_dav",   {7'd0, dav_tx},   8'd0);
      check("rp_dout",  dataout,          8'h00);
      check("rp_empty", {7'd0, tx_empty}, 8'd1);

      // Randomized traffic with varying consumer pace
      rf_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) rf_pct = int'($urandom_range(0, 100));
         step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
              1'($urandom),
              (int'($urandom_range(0, 99)) < rf_pct) ? 1'b1 : 1'b0,
              1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
